// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg -- shared definitions for the E-stage multiply/divide unit.
//   * op-code constants driven on e_mdu.op (codes 7..15 behave as NONE)
//   * default busy latencies for multiply and divide
//   * hilo_t: a 64-bit {hi, lo} result pair
//   * small op-class helper functions
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic is_mult(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// -----------------------------------------------------------------------------
// mdu_arith -- purely combinational 64-bit result for mult/multu/div/divu.
// Ports:
//   op      in  4   operation code (mdu_pkg)
//   rs_data in  32  operand A (multiplicand / dividend)
//   rt_data in  32  operand B (multiplier / divisor)
//   result  out 64  {hi, lo}; don't-care for non-arith ops and for divide by 0
// -----------------------------------------------------------------------------
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output hilo_t       result
);

    logic signed [63:0] a_s64;
    logic signed [63:0] b_s64;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        div_b;
    logic               div_ovf;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    assign a_s64  = {{32{rs_data[31]}}, rs_data};
    assign b_s64  = {{32{rt_data[31]}}, rt_data};
    assign prod_s = a_s64 * b_s64;
    assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

    // Substituting a divisor of 1 keeps the divider X-free for b == 0 (result is
    // discarded by the caller) and yields exactly the required 0x80000000 / -1
    // answer: quotient 0x80000000, remainder 0.
    assign div_ovf = (rs_data == 32'h8000_0000) && (rt_data == 32'hFFFF_FFFF);
    assign div_b   = ((rt_data == 32'd0) || div_ovf) ? 32'd1 : rt_data;

    // Signed / and % truncate toward zero; the remainder takes the dividend's sign.
    assign quot_s = $signed(rs_data) / $signed(div_b);
    assign rem_s  = $signed(rs_data) % $signed(div_b);
    assign quot_u = rs_data / div_b;
    assign rem_u  = rs_data % div_b;

    always_comb begin
        // NOTE: default assignment first so every path drives result -- no latch.
        result = '0;
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = '{hi: rem_s, lo: quot_s};
            OP_DIVU:  result = '{hi: rem_u, lo: quot_u};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// -----------------------------------------------------------------------------
// e_mdu -- E-stage multiply/divide unit with architectural HI/LO registers.
// The result is computed at accept and held in temp registers; busy then counts
// down the fixed latency and HI/LO are written on the edge that drops busy.
// Ports:
//   clk     in  1   rising-edge clock
//   reset   in  1   asynchronous active-high reset
//   start   in  1   op issued this cycle (ignored while busy)
//   op      in  4   operation code (mdu_pkg)
//   rs_data in  32  operand A
//   rt_data in  32  operand B
//   cancel  in  1   abort in-flight op (only with MDU_CANCEL_EN defined)
//   busy    out 1   multi-cycle op in flight
//   hi, lo  out 32  architectural HI / LO
// Optional feature macro: MDU_CANCEL_EN adds the cancel input.
// -----------------------------------------------------------------------------
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] MULT_CNT = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_CNT  = 5'(DIV_CYCLES);

    hilo_t       arith_res;
    hilo_t       temp;
    logic        temp_commit;   // cleared for divide-by-zero: HI/LO stay untouched
    logic [4:0]  count;
    logic        abort;

`ifdef MDU_CANCEL_EN
    assign abort = cancel;
`else
    assign abort = 1'b0;
`endif

    mdu_arith u_arith (
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .result  (arith_res)
    );

    // NOTE: sequential state uses non-blocking assignments only, and every
    // register (temp included) is cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            count       <= '0;
            temp        <= '0;
            temp_commit <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else if (abort) begin
            busy        <= 1'b0;
            count       <= '0;
            temp_commit <= 1'b0;
        end else if (busy) begin
            // start is ignored throughout the busy window, including the falling edge.
            if (count == 5'd1) begin
                busy  <= 1'b0;
                count <= '0;
                if (temp_commit) begin
                    hi <= temp.hi;
                    lo <= temp.lo;
                end
            end else begin
                count <= count - 5'd1;
            end
        end else if (start) begin
            if (is_mult(op)) begin
                busy        <= 1'b1;
                count       <= MULT_CNT;
                temp        <= arith_res;
                temp_commit <= 1'b1;
            end else if (is_div(op)) begin
                busy        <= 1'b1;
                count       <= DIV_CNT;
                temp        <= arith_res;
                temp_commit <= (rt_data != 32'd0);
            end else if (op == OP_MTHI) begin
                hi <= rs_data;
            end else if (op == OP_MTLO) begin
                lo <= rs_data;
            end
        end
    end

endmodule
